mod_share_ctrl: RTL and testbench

//   Shares one iterative modulo unit between NREQ requesters, round-robin.
//   Per request: if ^a is 1, result is a % b; if ^a is 0, result is 0.
//   The unit computes one remainder bit per cycle.

---
 rtl/mod_ctrl_pkg.sv | 26 ++
 rtl/mod_iter_unit.sv | 94 +++++++++
 rtl/mod_share_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mod_share_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_ctrl_pkg.sv
// mod_ctrl_pkg
//   Shared definitions for the round-robin shared modulo controller:
//   FSM state encoding and the requester-id width helper.
package mod_ctrl_pkg;

  // Controller states. IDLE arbitrates, CALC runs the iterative unit,
  // DONE presents the result until the consumer takes it.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Width of a requester index. A single requester would still need a 1-bit
  // id port, so the result never drops below 1.
  function automatic int id_w(input int n);
    int w;
    if (n > 32'sd1) begin
      w = $clog2(n);
    end else begin
      w = 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mod_iter_unit.sv
// mod_iter_unit
//   Iterative restoring remainder unit: one remainder bit per cycle,
//   MSB of the dividend first, W cycles per operation.
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset, discards any operation in flight
//   start  in   load a/b, clear the partial remainder, begin a new operation
//   a      in   W-bit dividend (sampled when start=1)
//   b      in   W-bit divisor (sampled when start=1, must be non-zero)
//   done   out  high in the cycle performing the last step
//   rem    out  remainder produced by the current step (valid when done=1)
module mod_iter_unit #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] rem
);

  localparam int CNT_W = (W > 32'sd1) ? $clog2(W) : 32'sd1;

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     r_q, r_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;

  logic [W:0]       t_s;
  logic [W:0]       diff_s;
  logic [W-1:0]     r_step_s;

  // One restoring step: shift in the next dividend bit, subtract b if it fits.
  // r < b always holds, so t < 2b and the restored value fits in W bits.
  always_comb begin
    t_s      = {r_q, a_q[cnt_q]};
    diff_s   = t_s - {1'b0, b_q};
    r_step_s = '0;
    if (t_s >= {1'b0, b_q}) begin
      r_step_s = diff_s[W-1:0];
    end else begin
      r_step_s = t_s[W-1:0];
    end
  end

  assign done = active_q && (cnt_q == '0);
  assign rem  = r_step_s;

  // Operation sequencing: load on start, then step down the bit counter.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    a_d      = a_q;
    b_d      = b_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = CNT_W'(W - 32'sd1);
      r_d      = '0;
      a_d      = a;
      b_d      = b;
    end else if (active_q) begin
      r_d = r_step_s;
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      active_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      r_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

endmodule

// File: rtl/mod_share_ctrl.sv
// mod_share_ctrl
//   Shares one iterative modulo unit between NREQ requesters with a
//   round-robin arbiter. Result per request: a % b when a has odd parity,
//   a itself when a has odd parity and b == 0, otherwise 0.
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req_valid  in   NREQ     requester i has an operand pair pending
//   req_a      in   NREQ*W   dividend of requester i at [i*W +: W]
//   req_b      in   NREQ*W   divisor of requester i at [i*W +: W]
//   req_ready  out  NREQ     one-hot accept; operands taken on this edge
//   rsp_valid  out  1        result available
//   rsp_id     out  ID_W     requester owning rsp_c
//   rsp_c      out  W        result
//   rsp_ready  in   1        consumer accepts result
//   busy       out  1        controller not idle
module mod_share_ctrl
  import mod_ctrl_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 4,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [W-1:0]      rsp_c,
  input  logic              rsp_ready,
  output logic              busy
);

  // Odd parity of a dividend gates whether any division happens at all.
  function automatic logic odd_parity(input logic [W-1:0] v);
    return ^v;
  endfunction

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [W-1:0]    rsp_c_q, rsp_c_d;

  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];

  logic            win_found_s;
  logic [ID_W-1:0] win_idx_s;
  logic [ID_W-1:0] cand_s;
  logic [W-1:0]    win_a_s;
  logic [W-1:0]    win_b_s;
  logic [ID_W-1:0] ptr_next_s;

  logic [NREQ-1:0] req_ready_s;
  logic            unit_start_s;
  logic            unit_done_s;
  logic [W-1:0]    unit_rem_s;

  // Unpack the flat operand buses so the winner can be selected by index.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*W +: W];
    assign b_arr[gi] = req_b[gi*W +: W];
  end

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = ID_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!win_found_s && req_valid[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
    win_a_s = a_arr[win_idx_s];
    win_b_s = b_arr[win_idx_s];
    if (win_idx_s == ID_W'(NREQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = win_idx_s + ID_W'(1);
    end
  end

  // Controller FSM: accept and decode in IDLE, wait for the unit in CALC,
  // hold the response in DONE until the consumer takes it.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    rsp_c_d      = rsp_c_q;
    req_ready_s  = '0;
    unit_start_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          req_ready_s[win_idx_s] = 1'b1;
          id_d                   = win_idx_s;
          rr_ptr_d               = ptr_next_s;
          if (!odd_parity(win_a_s)) begin
            rsp_c_d = '0;
            state_d = S_DONE;
          end else if (win_b_s == '0) begin
            // Division by zero returns the dividend instead of an undefined value.
            rsp_c_d = win_a_s;
            state_d = S_DONE;
          end else begin
            unit_start_s = 1'b1;
            state_d      = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (unit_done_s) begin
          rsp_c_d = unit_rem_s;
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        // No accept in the handshake cycle: arbitration restarts from IDLE.
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller registers with synchronous reset; reset drops any operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      rsp_c_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      rsp_c_q  <= rsp_c_d;
    end
  end

  mod_iter_unit #(
    .W (W)
  ) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (unit_start_s),
    .a     (win_a_s),
    .b     (win_b_s),
    .done  (unit_done_s),
    .rem   (unit_rem_s)
  );

  assign req_ready = req_ready_s;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_id    = id_q;
  assign rsp_c     = rsp_c_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mod_share_ctrl.sv
module tb_mod_share_ctrl;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int ID_W = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [W-1:0]      rsp_c;
  logic              rsp_ready;
  logic              busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [ID_W+W-1:0] sb_q [$];
  int                mdl_ptr;
  int                m_found;
  int                m_win;
  int                m_c;
  logic              hold_v;
  logic [ID_W+W-1:0] hold_val;
  logic [ID_W+W-1:0] exp_v;

  mod_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_c     (rsp_c),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mod_model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (^a == 1'b0) return '0;
    else if (b == '0) return a;
    else return a % b;
  endfunction

  // Monitor: arbitration model, scoreboard push at accept, pop at handshake,
  // response stability under backpressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      mdl_ptr = 0;
      hold_v  = 1'b0;
    end else begin
      if (!busy) begin
        m_found = 0;
        m_win   = 0;
        for (int k = 0; k < NREQ; k++) begin
          m_c = (mdl_ptr + k) % NREQ;
          if (m_found == 0 && req_valid[m_c]) begin
            m_found = 1;
            m_win   = m_c;
          end
        end
        check_val("arb_grant", 32'(req_ready), (m_found != 0) ? (32'd1 << m_win) : 32'd0);
        if (m_found != 0) begin
          sb_q.push_back({ID_W'(m_win), mod_model(req_a[m_win*W +: W], req_b[m_win*W +: W])});
          mdl_ptr = (m_win + 1) % NREQ;
        end
      end else begin
        check_val("rdy_busy", 32'(req_ready), 32'd0);
      end
      if (hold_v) begin
        check_val("rsp_hold", {rsp_valid, rsp_id, rsp_c}, {1'b1, hold_val});
      end
      hold_v   = rsp_valid && !rsp_ready;
      hold_val = {rsp_id, rsp_c};
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check_val("rsp_spurious", 32'd1, 32'd0);
        end else begin
          exp_v = sb_q.pop_front();
          check_val("rsp_data", {rsp_id, rsp_c}, exp_v);
        end
      end
    end
  end

  task automatic wait_accept(output int idx);
    idx = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int j = 0; j < NREQ; j++) begin
          if (req_ready[j]) idx = j;
        end
        break;
      end
    end
    if (idx < 0) check_val("accept_timeout", 32'd1, 32'd0);
  endtask

  // Counts cycles from the accept edge until rsp_valid; drops req_valid after accept.
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (i == 0) req_valid = '0;
      if (rsp_valid) break;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int g;
  int lat;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    cycles(3);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rsp_c", 32'(rsp_c), 32'd0);
    check_val("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    cycles(1);

    // T1 computed: 7 % 3
    req_a[0*W +: W] = 4'b0111; req_b[0*W +: W] = 4'd3; req_valid = 4'b0001;
    wait_accept(g);
    check_val("t1_grant", 32'(g), 32'd0);
    wait_rsp(lat);
    check_val("t1_latency", 32'(lat), 32'd5);
    check_val("t1_c", 32'(rsp_c), 32'd1);
    check_val("t1_id", 32'(rsp_id), 32'd0);
    cycles(2);

    // T2 gated: even parity
    req_a[1*W +: W] = 4'b0011; req_b[1*W +: W] = 4'd2; req_valid = 4'b0010;
    wait_accept(g);
    check_val("t2_grant", 32'(g), 32'd1);
    wait_rsp(lat);
    check_val("t2_latency", 32'(lat), 32'd1);
    check_val("t2_c", 32'(rsp_c), 32'd0);
    check_val("t2_id", 32'(rsp_id), 32'd1);
    cycles(2);

    // T3 divide by zero
    req_a[2*W +: W] = 4'b1101; req_b[2*W +: W] = 4'd0; req_valid = 4'b0100;
    wait_accept(g);
    check_val("t3_grant", 32'(g), 32'd2);
    wait_rsp(lat);
    check_val("t3_latency", 32'(lat), 32'd1);
    check_val("t3_c", 32'(rsp_c), 32'd13);
    check_val("t3_id", 32'(rsp_id), 32'd2);
    cycles(2);

    // T4 fairness from a fresh pointer
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    req_a = {NREQ{4'b0001}}; req_b = {NREQ{4'b0001}}; req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      wait_accept(g);
      check_val("t4_order", 32'(g), 32'(i % NREQ));
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    cycles(12);

    // T5 backpressure: 11 % 4 = 3 held while consumer stalls
    rsp_ready = 1'b0;
    req_a[0*W +: W] = 4'b1011; req_b[0*W +: W] = 4'd4; req_valid = 4'b0001;
    wait_accept(g);
    check_val("t5_grant", 32'(g), 32'd0);
    wait_rsp(lat);
    check_val("t5_latency", 32'(lat), 32'd5);
    req_a[1*W +: W] = 4'b0110; req_b[1*W +: W] = 4'd5; req_valid = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("t5_c", 32'(rsp_c), 32'd3);
      check_val("t5_id", 32'(rsp_id), 32'd0);
      check_val("t5_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("t5_release_valid", 32'(rsp_valid), 32'd0);
    check_val("t5_release_busy", 32'(busy), 32'd0);
    wait_accept(g);
    check_val("t5_next_grant", 32'(g), 32'd1);
    wait_rsp(lat);
    check_val("t5_next_latency", 32'(lat), 32'd1);
    cycles(2);

    // T6 reset during the second CALC cycle
    req_a[0*W +: W] = 4'b0111; req_b[0*W +: W] = 4'd3; req_valid = 4'b0001;
    wait_accept(g);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("t6_busy", 32'(busy), 32'd0);
    check_val("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("t6_no_stale", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    req_a[1*W +: W] = 4'b0100; req_b[1*W +: W] = 4'd3; req_valid = 4'b0011;
    wait_accept(g);
    check_val("t6_ptr_reset", 32'(g), 32'd0);
    wait_rsp(lat);
    cycles(8);

    // Random traffic against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      req_valid = NREQ'($urandom);
      req_a     = (NREQ*W)'($urandom);
      req_b     = (NREQ*W)'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    cycles(20);
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
